fetch_stage: RTL and testbench

Front end of the 5-stage RV32I pipeline. Generates the PC and drives a synchronous instruction memory with a fixed 1-cycle read latency. Holds the F/D pipeline register that feeds the decode stage (instruction, PC, PC+4, valid). Absorbs hazard-unit stalls with a 1-entry skid buffer and handles execute-stage redirects and decode flushes.

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundles the fetch stage's hazard-unit, redirect, instruction-memory and
// decode-facing signals. The fetch stage uses the master modport; the
// surrounding pipeline or bench uses the slave modport.
interface fetch_stage_if;
  // hazard unit
  logic        iStallD;
  logic        iFlushD;
  // execute-stage redirect
  logic        iPCSrcE;
  logic [31:0] iPCTargetE;
  // instruction memory
  logic        oImemReq;
  logic [31:0] oImemAddr;
  logic [31:0] iImemRdata;
  // F/D register toward decode
  logic [31:0] oInstructionD;
  logic [31:0] oPCD;
  logic [31:0] oPCPlus4D;
  logic        oValidD;

  modport master (
    input  iStallD, iFlushD, iPCSrcE, iPCTargetE, iImemRdata,
    output oImemReq, oImemAddr, oInstructionD, oPCD, oPCPlus4D, oValidD
  );

  modport slave (
    output iStallD, iFlushD, iPCSrcE, iPCTargetE, iImemRdata,
    input  oImemReq, oImemAddr, oInstructionD, oPCD, oPCPlus4D, oValidD
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC generation, 1-cycle-latency instruction memory
// requests, a one-entry skid buffer that catches the memory return while
// decode is stalled, and the F/D pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          iClk,
  input  logic          iRstN,
  fetch_stage_if.master bus
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // fetch PC
  logic [31:0] pc_f_q, pc_f_d;
  // request issued last cycle; its data is on iImemRdata now
  logic        v1_q, v1_d;
  logic [31:0] pc1_q, pc1_d;
  // skid buffer
  logic        vs_q, vs_d;
  logic [31:0] instr_s_q, instr_s_d;
  logic [31:0] pc_s_q, pc_s_d;
  // F/D register
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pc_plus4_d_q, pc_plus4_d_d;
  logic        valid_d_q, valid_d_d;

  logic        req;

  // A request is issued whenever decode can accept and no redirect is pending.
  // Including iRstN keeps the request low while reset is held.
  assign req           = iRstN & ~bus.iStallD & ~bus.iPCSrcE;
  assign bus.oImemReq  = req;
  assign bus.oImemAddr = pc_f_q & WORD_MASK;

  assign bus.oInstructionD = instr_d_q;
  assign bus.oPCD          = pc_d_q;
  assign bus.oPCPlus4D     = pc_plus4_d_q;
  assign bus.oValidD       = valid_d_q;

  // Next-state: redirect first, then stall/advance, then flush override.
  always_comb begin
    pc_f_d       = pc_f_q;
    v1_d         = v1_q;
    pc1_d        = pc1_q;
    vs_d         = vs_q;
    instr_s_d    = instr_s_q;
    pc_s_d       = pc_s_q;
    instr_d_d    = instr_d_q;
    pc_d_d       = pc_d_q;
    pc_plus4_d_d = pc_plus4_d_q;
    valid_d_d    = valid_d_q;

    if (bus.iPCSrcE) begin
      // Wrong-path work in flight and in the skid is discarded.
      pc_f_d    = bus.iPCTargetE & WORD_MASK;
      v1_d      = 1'b0;
      vs_d      = 1'b0;
      valid_d_d = 1'b0;
      instr_d_d = NOP_INSTR;
    end else begin
      if (req) begin
        pc_f_d = pc_f_q + 32'd4;
        v1_d   = 1'b1;
        pc1_d  = pc_f_q;
      end else begin
        v1_d   = 1'b0;
      end

      if (bus.iStallD) begin
        // No request is made while stalled, so the skid can only fill from
        // the return of the last pre-stall request.
        if (v1_q) begin
          vs_d      = 1'b1;
          instr_s_d = bus.iImemRdata;
          pc_s_d    = pc1_q;
        end
      end else if (vs_q) begin
        instr_d_d    = instr_s_q;
        pc_d_d       = pc_s_q;
        pc_plus4_d_d = pc_s_q + 32'd4;
        valid_d_d    = 1'b1;
        vs_d         = 1'b0;
      end else if (v1_q) begin
        instr_d_d    = bus.iImemRdata;
        pc_d_d       = pc1_q;
        pc_plus4_d_d = pc1_q + 32'd4;
        valid_d_d    = 1'b1;
      end else begin
        valid_d_d    = 1'b0;
        instr_d_d    = NOP_INSTR;
      end

      // Flush kills the decode slot even while stalled.
      if (bus.iFlushD) begin
        valid_d_d = 1'b0;
        instr_d_d = NOP_INSTR;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      pc_f_q       <= RESET_PC;
      v1_q         <= 1'b0;
      pc1_q        <= 32'd0;
      vs_q         <= 1'b0;
      instr_s_q    <= NOP_INSTR;
      pc_s_q       <= 32'd0;
      instr_d_q    <= NOP_INSTR;
      pc_d_q       <= 32'd0;
      pc_plus4_d_q <= 32'd0;
      valid_d_q    <= 1'b0;
    end else begin
      pc_f_q       <= pc_f_d;
      v1_q         <= v1_d;
      pc1_q        <= pc1_d;
      vs_q         <= vs_d;
      instr_s_q    <= instr_s_d;
      pc_s_q       <= pc_s_d;
      instr_d_q    <= instr_d_d;
      pc_d_q       <= pc_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle-latency instruction memory.
module tb_fetch_stage;
  logic iClk;
  logic iRstN;
  int   n_assert;
  int   n_fail;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Memory contents: two fixed words at 0x0/0x4, otherwise {addr[19:0],12'h013}.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0050_0093;
      32'h4: return 32'h00A0_0113;
      default: return {a[19:0], 12'h013};
    endcase
  endfunction

  // Synchronous memory, not reset: a stale return can sit on rdata after reset.
  always @(posedge iClk) begin
    if (bus.oImemReq) bus.iImemRdata <= mem_word(bus.oImemAddr);
  end

  // Structural invariant: never a live in-flight return and a full skid together.
  always @(negedge iClk) begin
    if (iRstN) begin
      n_assert++;
      if (dut.v1_q && dut.vs_q) begin
        n_fail++;
        $display("FAIL invariant_v1_vs: v1=%0b vs=%0b required not both 1 at %0t", dut.v1_q, dut.vs_q, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iRstN          = 1'b0;
    bus.iStallD    = 1'b0;
    bus.iFlushD    = 1'b0;
    bus.iPCSrcE    = 1'b0;
    bus.iPCTargetE = 32'h0;
    bus.iImemRdata = 32'h0;
    step();
    step();
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD, bus.oPCD, bus.oPCPlus4D, bus.oImemReq} !==
        {1'b0, 32'h13, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: v=%0b i=%h pc=%h pc4=%h req=%0b required 0/00000013/0/0/0",
               bus.oValidD, bus.oInstructionD, bus.oPCD, bus.oPCPlus4D, bus.oImemReq);
    end
  endtask

  // Release reset and see the first two instructions arrive.
  task automatic test_first_fetch();
    @(negedge iClk);
    iRstN = 1'b1;
    #1;
    n_assert++;
    if ({bus.oImemReq, bus.oImemAddr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL first_req: req=%0b addr=%h required 1/00000000", bus.oImemReq, bus.oImemAddr);
    end
    step();
    n_assert++;
    if (bus.oValidD !== 1'b0) begin
      n_fail++;
      $display("FAIL first_latency: valid=%0b required 0", bus.oValidD);
    end
    step();
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD, bus.oPCD, bus.oPCPlus4D} !==
        {1'b1, 32'h0050_0093, 32'h0, 32'h4}) begin
      n_fail++;
      $display("FAIL first_instr: v=%0b i=%h pc=%h pc4=%h required 1/00500093/0/4",
               bus.oValidD, bus.oInstructionD, bus.oPCD, bus.oPCPlus4D);
    end
    step();
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD, bus.oPCD} !== {1'b1, 32'h00A0_0113, 32'h4}) begin
      n_fail++;
      $display("FAIL second_instr: v=%0b i=%h pc=%h required 1/00a00113/4",
               bus.oValidD, bus.oInstructionD, bus.oPCD);
    end
  endtask

  // 0x8 return is in flight; stall 3 cycles, then drain skid then live stream.
  task automatic test_stall_skid();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc = '{32'h8, 32'hC, 32'h10};
    exp_in = '{32'h0000_8013, 32'h0000_C013, 32'h0001_0013};
    bus.iStallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_assert++;
      if (bus.oImemReq !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_req[%0d]: req=%0b required 0", i, bus.oImemReq);
      end
      step();
      n_assert++;
      if ({bus.oValidD, bus.oInstructionD, bus.oPCD} !== {1'b1, 32'h00A0_0113, 32'h4}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: v=%0b i=%h pc=%h required 1/00a00113/4",
                 i, bus.oValidD, bus.oInstructionD, bus.oPCD);
      end
    end
    bus.iStallD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_assert++;
      if ({bus.oValidD, bus.oInstructionD, bus.oPCD, bus.oPCPlus4D} !==
          {1'b1, exp_in[i], exp_pc[i], exp_pc[i] + 32'd4}) begin
        n_fail++;
        $display("FAIL stall_release[%0d]: v=%0b i=%h pc=%h pc4=%h required 1/%h/%h/%h",
                 i, bus.oValidD, bus.oInstructionD, bus.oPCD, bus.oPCPlus4D,
                 exp_in[i], exp_pc[i], exp_pc[i] + 32'd4);
      end
    end
  endtask

  // Redirect to unaligned 0x102 with the 0x14 return in flight.
  task automatic test_redirect();
    bus.iPCSrcE    = 1'b1;
    bus.iPCTargetE = 32'h0000_0102;
    #1;
    n_assert++;
    if (bus.oImemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_req: req=%0b required 0", bus.oImemReq);
    end
    step();
    bus.iPCSrcE = 1'b0;
    #1;
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD, bus.oImemReq, bus.oImemAddr} !==
        {1'b0, 32'h13, 1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL redirect_next: v=%0b i=%h req=%0b addr=%h required 0/00000013/1/00000100",
               bus.oValidD, bus.oInstructionD, bus.oImemReq, bus.oImemAddr);
    end
    step();
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD} !== {1'b0, 32'h13}) begin
      n_fail++;
      $display("FAIL redirect_stale: v=%0b i=%h required 0/00000013", bus.oValidD, bus.oInstructionD);
    end
    step();
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD, bus.oPCD, bus.oPCPlus4D} !==
        {1'b1, 32'h0010_0013, 32'h100, 32'h104}) begin
      n_fail++;
      $display("FAIL redirect_target: v=%0b i=%h pc=%h pc4=%h required 1/00100013/100/104",
               bus.oValidD, bus.oInstructionD, bus.oPCD, bus.oPCPlus4D);
    end
  endtask

  // Fill the skid with 0x104, then redirect to 0x200 while still stalled.
  task automatic test_redirect_over_stall();
    bus.iStallD = 1'b1;
    step();
    n_assert++;
    if ({bus.oValidD, bus.oPCD} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL skid_fill_hold: v=%0b pc=%h required 1/100", bus.oValidD, bus.oPCD);
    end
    bus.iPCSrcE    = 1'b1;
    bus.iPCTargetE = 32'h0000_0200;
    step();
    bus.iPCSrcE = 1'b0;
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD} !== {1'b0, 32'h13}) begin
      n_fail++;
      $display("FAIL redir_stall_bubble: v=%0b i=%h required 0/00000013", bus.oValidD, bus.oInstructionD);
    end
    step();
    n_assert++;
    if ({bus.oValidD, bus.oImemReq} !== {1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL redir_stall_hold: v=%0b req=%0b required 0/0", bus.oValidD, bus.oImemReq);
    end
    bus.iStallD = 1'b0;
    #1;
    n_assert++;
    if ({bus.oImemReq, bus.oImemAddr} !== {1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL redir_stall_addr: req=%0b addr=%h required 1/00000200", bus.oImemReq, bus.oImemAddr);
    end
    step();
    n_assert++;
    if (bus.oValidD !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_stall_skid_dropped: v=%0b pc=%h required v=0", bus.oValidD, bus.oPCD);
    end
    step();
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD, bus.oPCD} !== {1'b1, 32'h0020_0013, 32'h200}) begin
      n_fail++;
      $display("FAIL redir_stall_target: v=%0b i=%h pc=%h required 1/00200013/200",
               bus.oValidD, bus.oInstructionD, bus.oPCD);
    end
  endtask

  // Flush during a stall; 0x204 is caught by the skid and still delivered.
  task automatic test_flush_stall();
    bus.iStallD = 1'b1;
    bus.iFlushD = 1'b1;
    step();
    bus.iStallD = 1'b0;
    bus.iFlushD = 1'b0;
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD} !== {1'b0, 32'h13}) begin
      n_fail++;
      $display("FAIL flush_bubble: v=%0b i=%h required 0/00000013", bus.oValidD, bus.oInstructionD);
    end
    step();
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD, bus.oPCD} !== {1'b1, 32'h0020_4013, 32'h204}) begin
      n_fail++;
      $display("FAIL flush_resume0: v=%0b i=%h pc=%h required 1/00204013/204",
               bus.oValidD, bus.oInstructionD, bus.oPCD);
    end
    step();
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD, bus.oPCD} !== {1'b1, 32'h0020_8013, 32'h208}) begin
      n_fail++;
      $display("FAIL flush_resume1: v=%0b i=%h pc=%h required 1/00208013/208",
               bus.oValidD, bus.oInstructionD, bus.oPCD);
    end
  endtask

  // Async reset mid-cycle with the skid holding 0x20C.
  task automatic test_async_reset();
    bus.iStallD = 1'b1;
    step();
    n_assert++;
    if ({bus.oValidD, bus.oPCD} !== {1'b1, 32'h208}) begin
      n_fail++;
      $display("FAIL pre_reset_hold: v=%0b pc=%h required 1/208", bus.oValidD, bus.oPCD);
    end
    #1;
    iRstN = 1'b0;
    #1;
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD, bus.oPCD, bus.oPCPlus4D, bus.oImemReq} !==
        {1'b0, 32'h13, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: v=%0b i=%h pc=%h pc4=%h req=%0b required 0/00000013/0/0/0",
               bus.oValidD, bus.oInstructionD, bus.oPCD, bus.oPCPlus4D, bus.oImemReq);
    end
    bus.iStallD = 1'b0;
    step();
    step();
    @(negedge iClk);
    iRstN = 1'b1;
    #1;
    n_assert++;
    if ({bus.oImemReq, bus.oImemAddr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL restart_addr: req=%0b addr=%h required 1/00000000", bus.oImemReq, bus.oImemAddr);
    end
    step();
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD} !== {1'b0, 32'h13}) begin
      n_fail++;
      $display("FAIL restart_stale_ignored: v=%0b i=%h required 0/00000013", bus.oValidD, bus.oInstructionD);
    end
    step();
    n_assert++;
    if ({bus.oValidD, bus.oInstructionD, bus.oPCD} !== {1'b1, 32'h0050_0093, 32'h0}) begin
      n_fail++;
      $display("FAIL restart_first: v=%0b i=%h pc=%h required 1/00500093/0",
               bus.oValidD, bus.oInstructionD, bus.oPCD);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_first_fetch();
    test_stall_skid();
    test_redirect();
    test_redirect_over_stall();
    test_flush_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
